cell_broadcast_receiver: RTL and testbench

Per-cell receiving end of the broadcast read protocol driven by the broadcast controller. Each cell instantiates one. The block:
- latches the cell's particle count at iteration start;
- turns each broadcast particle ID into a read of the cell's position cache;
- buffers the returned records for the filter stage;
- reports `back_pressure`, `filter_buffer_empty` and `reading_done` back to the controller.

---
 rtl/cell_broadcast_receiver.sv | 136 +++++++++++++
 tb/tb_cell_broadcast_receiver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_broadcast_receiver.sv
// Per-cell receiver for the broadcast read protocol: turns broadcast particle IDs into
// position-cache reads and queues the returned records for the filter stage.
module cell_broadcast_receiver #(
  parameter int PID_W      = 7,
  parameter int DATA_W     = 96,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PID_W-1:0]  particle_id,
  input  logic [PID_W-1:0]  ref_id,
  input  logic              phase,
  input  logic              reading_particle_num,
  input  logic              pause_reading,
  output logic              rd_en,
  output logic [PID_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [PID_W-1:0]  rec_ref_id,
  output logic [PID_W-1:0]  rec_pid,
  output logic              rec_phase,
  output logic [DATA_W-1:0] rec_pos,
  output logic [PID_W-1:0]  particle_count,
  output logic              back_pressure,
  output logic              filter_buffer_empty,
  output logic              reading_done,
  output logic              overflow_err
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int REC_W = 2 * PID_W + 1 + DATA_W;
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW+1:0] BP_LEVEL = (AW+2)'(FIFO_DEPTH - 2);

  logic count_rd;
  logic data_rd;
  logic push;
  logic pop;
  logic full;
  logic do_write;
  logic count_return;

  logic [PID_W-1:0] particle_count_q, particle_count_d;
  logic             count_pending_q, count_pending_d;
  logic             inflight_q;
  logic             inflight_kind_q;
  logic [PID_W-1:0] inflight_ref_q;
  logic [PID_W-1:0] inflight_pid_q;
  logic             inflight_phase_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic             back_pressure_q, back_pressure_d;
  logic             reading_done_q, reading_done_d;
  logic             overflow_err_q, overflow_err_d;
  logic [REC_W-1:0] mem_q [FIFO_DEPTH];

  // Read issue is purely combinational so the controller sees zero issue latency.
  always_comb begin
    count_rd = reading_particle_num && !pause_reading;
    data_rd  = !reading_particle_num && !pause_reading && (particle_id != '0) &&
               (particle_id <= particle_count_q) && !count_pending_q;
    rd_en    = count_rd || data_rd;
    rd_addr  = count_rd ? '0 : particle_id;
  end

  always_comb begin
    count_return     = inflight_q && inflight_kind_q;
    push             = inflight_q && !inflight_kind_q;
    pop              = rec_valid && rec_ready;
    full             = (occ_q == OCC_FULL);
    do_write         = push && (!full || pop);
    wr_ptr_d         = wr_ptr_q + AW'(do_write);
    rd_ptr_d         = rd_ptr_q + AW'(pop);
    occ_d            = occ_q;
    if (do_write && !pop) occ_d = occ_q + OCC_ONE;
    else if (!do_write && pop) occ_d = occ_q - OCC_ONE;
    overflow_err_d   = overflow_err_q || (push && full && !pop);
    particle_count_d = count_return ? rd_data[PID_W-1:0] : particle_count_q;
    count_pending_d  = count_pending_q;
    if (count_rd) count_pending_d = 1'b1;
    else if (count_return) count_pending_d = 1'b0;
    // Margin of two covers the read issued while the controller samples the flag, plus its return.
    back_pressure_d  = ({1'b0, occ_d} + (AW+2)'(rd_en)) >= BP_LEVEL;
    reading_done_d   = !count_pending_q && !reading_particle_num && (ref_id > particle_count_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      particle_count_q <= '0;
      count_pending_q  <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_kind_q  <= 1'b0;
      inflight_ref_q   <= '0;
      inflight_pid_q   <= '0;
      inflight_phase_q <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      occ_q            <= '0;
      back_pressure_q  <= 1'b0;
      reading_done_q   <= 1'b0;
      overflow_err_q   <= 1'b0;
    end else begin
      particle_count_q <= particle_count_d;
      count_pending_q  <= count_pending_d;
      inflight_q       <= rd_en;
      if (rd_en) begin
        inflight_kind_q  <= count_rd;
        inflight_ref_q   <= ref_id;
        inflight_pid_q   <= particle_id;
        inflight_phase_q <= phase;
      end
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      occ_q            <= occ_d;
      back_pressure_q  <= back_pressure_d;
      reading_done_q   <= reading_done_d;
      overflow_err_q   <= overflow_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= {inflight_ref_q, inflight_pid_q, inflight_phase_q, rd_data};
  end

  assign rec_valid                                  = (occ_q != '0);
  assign {rec_ref_id, rec_pid, rec_phase, rec_pos}  = mem_q[rd_ptr_q];
  assign particle_count                             = particle_count_q;
  assign back_pressure                              = back_pressure_q;
  assign reading_done                               = reading_done_q;
  assign overflow_err                               = overflow_err_q;
  assign filter_buffer_empty = (occ_q == '0) && !inflight_q && !count_pending_q;

endmodule

// File: tb/tb_cell_broadcast_receiver.sv
// Randomized scoreboard bench for cell_broadcast_receiver: stimulus predicts records from the
// read rules, a negedge monitor pops and compares every record the filter accepts.
module tb_cell_broadcast_receiver;

  localparam int PID_W  = 7;
  localparam int DATA_W = 96;
  localparam int DEPTH  = 8;

  typedef struct {
    logic [PID_W-1:0]  ref_id;
    logic [PID_W-1:0]  pid;
    logic              phase;
    logic [DATA_W-1:0] pos;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [PID_W-1:0]  particle_id = '0;
  logic [PID_W-1:0]  ref_id = '0;
  logic              phase = 1'b0;
  logic              reading_particle_num = 1'b0;
  logic              pause_reading = 1'b1;
  logic              rd_en;
  logic [PID_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic              rec_valid;
  logic              rec_ready = 1'b0;
  logic [PID_W-1:0]  rec_ref_id;
  logic [PID_W-1:0]  rec_pid;
  logic              rec_phase;
  logic [DATA_W-1:0] rec_pos;
  logic [PID_W-1:0]  particle_count;
  logic              back_pressure;
  logic              filter_buffer_empty;
  logic              reading_done;
  logic              overflow_err;

  logic [DATA_W-1:0] cache [128];
  rec_t exp_q[$];
  rec_t mon_e;
  int checks = 0;
  int errors = 0;
  int m_count = 0;
  bit m_pending = 0;
  int push_budget = 1000000;

  cell_broadcast_receiver #(.PID_W(PID_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .particle_id(particle_id), .ref_id(ref_id), .phase(phase),
    .reading_particle_num(reading_particle_num), .pause_reading(pause_reading),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_ref_id(rec_ref_id), .rec_pid(rec_pid),
    .rec_phase(rec_phase), .rec_pos(rec_pos), .particle_count(particle_count),
    .back_pressure(back_pressure), .filter_buffer_empty(filter_buffer_empty),
    .reading_done(reading_done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Position cache: one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= cache[rd_addr];

  always @(negedge clk) begin
    if (!rst && rec_valid && rec_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got pid %0d ref %0d, required no record", rec_pid, rec_ref_id);
      end else begin
        mon_e = exp_q.pop_front();
        if (rec_pid !== mon_e.pid || rec_ref_id !== mon_e.ref_id || rec_phase !== mon_e.phase ||
            rec_pos !== mon_e.pos) begin
          errors++;
          $display("FAIL record: got pid %0d ref %0d ph %0b pos %0h, required pid %0d ref %0d ph %0b pos %0h",
                   rec_pid, rec_ref_id, rec_phase, rec_pos, mon_e.pid, mon_e.ref_id, mon_e.phase, mon_e.pos);
        end else begin
          $display("record pid=%0d ref=%0d phase=%0b ok", rec_pid, rec_ref_id, rec_phase);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive one broadcast cycle; the model decides whether a read is due and predicts its record.
  task automatic issue(input logic rpn, input logic pause, input int pid, input int rf, input logic ph);
    logic exp_en;
    logic [PID_W-1:0] exp_addr;
    reading_particle_num = rpn;
    pause_reading        = pause;
    particle_id          = PID_W'(pid);
    ref_id               = PID_W'(rf);
    phase                = ph;
    exp_en   = 1'b0;
    exp_addr = PID_W'(pid);
    if (!pause && rpn) begin
      exp_en   = 1'b1;
      exp_addr = '0;
    end else if (!pause && !rpn && !m_pending && pid >= 1 && pid <= m_count) begin
      exp_en = 1'b1;
      if (push_budget > 0) begin
        exp_q.push_back('{PID_W'(rf), PID_W'(pid), ph, cache[pid]});
        push_budget--;
      end
    end
    m_pending = !pause && rpn;
    if (m_pending) m_count = int'(cache[0][PID_W-1:0]);
    #1;
    check("rd_en", rd_en, exp_en);
    if (exp_en) check("rd_addr", rd_addr, exp_addr);
    @(posedge clk); #1;
  endtask

  task automatic count_read(input int c, input int rf);
    cache[0] = DATA_W'(c);
    issue(1'b1, 1'b0, 0, rf, 1'b0);
    issue(1'b0, 1'b0, 1, rf, 1'b0);
  endtask

  task automatic drain(input int rf);
    int n;
    n = 0;
    rec_ready = 1'b1;
    while (!(filter_buffer_empty && exp_q.size() == 0) && n < 300) begin
      issue(1'b0, 1'b1, 0, rf, 1'b0);
      n++;
    end
    check("drain_done", filter_buffer_empty && (exp_q.size() == 0), 1'b1);
  endtask

  initial begin
    int pid;
    int first_bp;
    int c;
    for (int i = 0; i < 128; i++) cache[i] = {$urandom, $urandom, $urandom};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_rec_valid", rec_valid, 1'b0);
    check("reset_particle_count", particle_count, 0);
    check("reset_back_pressure", back_pressure, 1'b0);
    check("reset_reading_done", reading_done, 1'b0);
    check("reset_overflow_err", overflow_err, 1'b0);
    check("reset_fbe", filter_buffer_empty, 1'b1);

    // Count read of 5, then broadcast 1..7: only 1..5 may read.
    cache[0] = DATA_W'(5);
    issue(1'b1, 1'b0, 0, 1, 1'b0);
    check("fbe_count_inflight", filter_buffer_empty, 1'b0);
    issue(1'b0, 1'b0, 1, 1, 1'b0);
    check("count_5", particle_count, 5);
    check("fbe_after_count", filter_buffer_empty, 1'b1);
    issue(1'b0, 1'b1, 0, 1, 1'b0);
    check("done_ref1_count5", reading_done, 1'b0);
    rec_ready = 1'b1;
    for (int p = 1; p <= 7; p++) issue(1'b0, 1'b0, p, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    drain(1);

    // Back-pressure with a controller that pauses while the flag is high.
    count_read(8, 2);
    check("count_8", particle_count, 8);
    rec_ready = 1'b0;
    pid = 1;
    first_bp = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc == 30) rec_ready = 1'b1;
      if (back_pressure && first_bp < 0) first_bp = pid - 1;
      if (!back_pressure && pid <= 8) begin
        issue(1'b0, 1'b0, pid, 2, 1'b1);
        pid++;
      end else begin
        issue(1'b0, 1'b1, 0, 2, 1'b1);
      end
    end
    check("bp_first_at_6_issued", first_bp, 6);
    check("bp_all_issued", pid, 9);
    check("bp_no_overflow", overflow_err, 1'b0);
    drain(2);

    // reading_done: count 3 with ref 3 then 4.
    count_read(3, 3);
    issue(1'b0, 1'b1, 0, 3, 1'b0);
    check("done_ref3", reading_done, 1'b0);
    issue(1'b0, 1'b1, 0, 4, 1'b0);
    check("done_ref4", reading_done, 1'b1);
    // Count 0 lands two cycles after the count read.
    cache[0] = '0;
    issue(1'b1, 1'b0, 0, 1, 1'b0);
    issue(1'b0, 1'b1, 0, 1, 1'b0);
    check("done_count0_pending", reading_done, 1'b0);
    check("count_0", particle_count, 0);
    issue(1'b0, 1'b1, 0, 1, 1'b0);
    check("done_count0", reading_done, 1'b1);

    // Randomized broadcast with a conforming controller.
    c = $urandom_range(3, 20);
    count_read(c, 5);
    check("count_rand", particle_count, c);
    for (int cyc = 0; cyc < 300; cyc++) begin
      rec_ready = ($urandom_range(0, 3) != 0);
      issue(1'b0, back_pressure || ($urandom_range(0, 3) == 0), $urandom_range(0, 25),
            $urandom_range(0, 127), 1'($urandom_range(0, 1)));
    end
    check("rand_no_overflow", overflow_err, 1'b0);
    drain(5);

    // Forced overflow: ten reads into an eight-deep FIFO with no drain.
    count_read(10, 1);
    rec_ready = 1'b0;
    push_budget = DEPTH;
    for (int p = 1; p <= 10; p++) issue(1'b0, 1'b0, p, 1, 1'b0);
    push_budget = 1000000;
    repeat (2) issue(1'b0, 1'b1, 0, 1, 1'b0);
    check("overflow_set", overflow_err, 1'b1);
    check("overflow_rec_valid", rec_valid, 1'b1);
    repeat (5) issue(1'b0, 1'b1, 0, 1, 1'b0);
    check("overflow_sticky", overflow_err, 1'b1);
    drain(1);
    check("overflow_sticky_drained", overflow_err, 1'b1);

    // Reset with a full FIFO and a data read in flight.
    count_read(10, 1);
    rec_ready = 1'b0;
    for (int p = 1; p <= 9; p++) issue(1'b0, 1'b0, p, 1, 1'b0);
    check("prerst_rec_valid", rec_valid, 1'b1);
    check("prerst_fbe", filter_buffer_empty, 1'b0);
    rst = 1'b1;
    issue(1'b0, 1'b1, 0, 1, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_pending = 0;
    check("rst_rec_valid", rec_valid, 1'b0);
    check("rst_fbe", filter_buffer_empty, 1'b1);
    check("rst_count", particle_count, 0);
    check("rst_overflow", overflow_err, 1'b0);
    check("rst_bp", back_pressure, 1'b0);

    // Recovery after reset.
    count_read(2, 1);
    rec_ready = 1'b1;
    for (int p = 1; p <= 3; p++) issue(1'b0, 1'b0, p, 1, 1'b1);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
